hams_pair_gather: RTL and testbench

Serial-to-parallel front end for the HAMS sort pipeline. Accepts one `pair` per cycle from the streaming input, packs `NUM_ELEMENTS` consecutive pairs into one vector, and presents it with a one-cycle valid strobe directly to the `unsorted`/`valid` inputs of the element-sort stage. Partial final groups (end of stream or explicit flush) are padded with the sentinel `PAIR_PAD` so downstream stages always see full vectors.

---
 rtl/hams_pkg.sv | 23 ++
 rtl/hams_pair_gather.sv | 145 ++++++++++++++
 tb/tb_hams_pair_gather.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hams_pkg.sv
// Shared types for the HAMS sort pipeline: the key/value `pair` element,
// the pad sentinel used to fill short vectors, and the gather FSM states.
package hams_pkg;

    localparam int KEY_W = 16;
    localparam int VAL_W = 16;

    // One sortable element: ordering is by key, value rides along.
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } pair;

    // All-ones key and value so padding sorts to the end under ascending order.
    localparam pair PAIR_PAD = '{key: {KEY_W{1'b1}}, value: {VAL_W{1'b1}}};

    // EMPTY: no element held in the fill buffer. FILL: at least one held.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } gather_state_e;

endpackage

// File: rtl/hams_pair_gather.sv
// Serial-to-parallel gather for the HAMS sort front end. Packs consecutive
// input pairs into NUM_ELEMENTS-wide vectors and emits each one with a
// single-cycle valid strobe. Short groups (in_last or flush) are padded
// with PAIR_PAD so the sort stage always receives a full vector.
//
// Handshake: an element transfers on a rising edge where in_valid && in_ready.
// in_ready is held high from the first edge after reset release because the
// sort stage cannot stall; valid_o is a strobe with no ready of its own.
module hams_pair_gather
    import hams_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8,
    localparam int CW  = $clog2(NUM_ELEMENTS),
    localparam int NVW = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  pair                         in_pair,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    input  logic                        flush,
    output pair [NUM_ELEMENTS-1:0]      gathered,
    output logic                        valid_o,
    output logic [NVW-1:0]              num_valid,
    output logic                        last_o,
    output gather_state_e               dbg_state
);

    gather_state_e          state_q;
    gather_state_e          state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    pair                    buf_q [NUM_ELEMENTS];
    logic                   ready_q;

    logic                   accept;
    logic                   group_full;
    logic                   close_grp;
    logic [NVW-1:0]         fill_cnt;
    pair [NUM_ELEMENTS-1:0] close_vec;

    pair [NUM_ELEMENTS-1:0] gathered_q;
    logic                   valid_q;
    logic [NVW-1:0]         num_valid_q;
    logic                   last_q;

    assign accept     = in_valid && ready_q;
    assign group_full = accept && (cnt_q == CW'(NUM_ELEMENTS - 1));
    // Real elements in the group if it were to close this cycle.
    assign fill_cnt   = NVW'(cnt_q) + NVW'(accept);

    assign in_ready   = ready_q;
    assign gathered   = gathered_q;
    assign valid_o    = valid_q;
    assign num_valid  = num_valid_q;
    assign last_o     = last_q;
    assign dbg_state  = state_q;

    // Ready comes up on the first edge after reset release and stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // FSM state register together with the fill counter it summarises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a close always empties the buffer, even if it took an element.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (close_grp) begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ST_FILL;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Close decision: flush alone only closes when something is buffered.
    always_comb begin
        close_grp = 1'b0;
        case (state_q)
            ST_EMPTY: close_grp = accept && (group_full || in_last || flush);
            ST_FILL:  close_grp = flush || (accept && (group_full || in_last));
            default:  close_grp = 1'b0;
        endcase
    end

    // Vector presented on close: buffered slots, the closing element, then pad.
    always_comb begin
        close_vec = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (accept && (CW'(i) == cnt_q)) begin
                close_vec[i] = in_pair;
            end else if (NVW'(i) < NVW'(cnt_q)) begin
                close_vec[i] = buf_q[i];
            end else begin
                close_vec[i] = PAIR_PAD;
            end
        end
    end

    // Fill buffer: the k-th accepted element of a group lands at index k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (accept) begin
            buf_q[cnt_q] <= in_pair;
        end
    end

    // Output register: strobe every close, hold vector and tags until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            gathered_q  <= '0;
            num_valid_q <= '0;
            last_q      <= 1'b0;
        end else begin
            valid_q <= close_grp;
            if (close_grp) begin
                gathered_q  <= close_vec;
                num_valid_q <= fill_cnt;
                last_q      <= accept && in_last;
            end
        end
    end

endmodule

// File: tb/tb_hams_pair_gather.sv
// Directed and randomised-gap checks for hams_pair_gather.
module tb_hams_pair_gather;
    import hams_pkg::*;

    localparam int N   = 8;
    localparam int NVW = $clog2(N + 1);
    localparam int PW  = $bits(pair);
    localparam int VW  = N * PW;

    logic              clk;
    logic              rst_n;
    pair               in_pair;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              flush;
    pair [N-1:0]       gathered;
    logic              valid_o;
    logic [NVW-1:0]    num_valid;
    logic              last_o;
    gather_state_e     dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [VW-1:0]  got_vec_q [$];
    logic [NVW-1:0] got_nv_q [$];
    logic           got_last_q [$];
    int             got_cyc_q [$];

    logic [VW-1:0]  exp_q [$];
    logic [NVW-1:0] exp_nv_q [$];
    logic           exp_last_q [$];

    hams_pair_gather #(.NUM_ELEMENTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pair   (in_pair),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .flush     (flush),
        .gathered  (gathered),
        .valid_o   (valid_o),
        .num_valid (num_valid),
        .last_o    (last_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            got_vec_q.push_back(gathered);
            got_nv_q.push_back(num_valid);
            got_last_q.push_back(last_o);
            got_cyc_q.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    function automatic pair mk_pair(input logic [15:0] k);
        pair p;
        p.key   = k;
        p.value = k ^ 16'h5a5a;
        return p;
    endfunction

    // Consecutive keys base..base+n-1 in slots 0..n-1, pad above.
    function automatic logic [VW-1:0] build_vec(input logic [15:0] base, input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i < n) v[i*PW +: PW] = mk_pair(base + 16'(i));
            else       v[i*PW +: PW] = PAIR_PAD;
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic [15:0] k, input logic l, input logic f);
        in_valid = v;
        in_pair  = mk_pair(k);
        in_last  = l;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_capture();
        got_vec_q.delete();
        got_nv_q.delete();
        got_last_q.delete();
        got_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_pair = '0;
        #3;
        tests_run++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || num_valid !== '0 || gathered !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b last=%b nv=%0d vec=%0h, expected all zero",
                     valid_o, last_o, num_valid, gathered);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        idle(2);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_edge: got %b expected 1", in_ready);
        end
        tests_run++;
        if (dbg_state !== ST_EMPTY || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_state: got state=%0d valid=%b expected state=0 valid=0",
                     dbg_state, valid_o);
        end
    endtask

    task automatic test_full_group();
        int c0;
        clear_capture();
        c0 = cyc;
        for (int k = 1; k <= 8; k++) drive(1'b1, 16'(k), k == 8, 1'b0);
        idle(3);
        tests_run++;
        if (got_vec_q.size() != 1) begin
            tests_failed++;
            $display("FAIL full_count: got %0d strobes expected 1", got_vec_q.size());
        end
        if (got_vec_q.size() >= 1) begin
            tests_run++;
            if (got_vec_q[0] !== build_vec(16'd1, 8)) begin
                tests_failed++;
                $display("FAIL full_vec: got %0h expected %0h", got_vec_q[0], build_vec(16'd1, 8));
            end
            tests_run++;
            if (got_nv_q[0] !== NVW'(8) || got_last_q[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_tags: got nv=%0d last=%b expected nv=8 last=1",
                         got_nv_q[0], got_last_q[0]);
            end
            tests_run++;
            if (got_cyc_q[0] - c0 + 1 != 9) begin
                tests_failed++;
                $display("FAIL full_latency: got cycle %0d expected 9", got_cyc_q[0] - c0 + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int exp_cyc [3];
        int exp_n [3];
        logic exp_l [3];
        exp_cyc = '{9, 17, 20};
        exp_n   = '{8, 8, 3};
        exp_l   = '{1'b0, 1'b0, 1'b1};
        clear_capture();
        c0 = cyc;
        for (int k = 0; k < 19; k++) drive(1'b1, 16'h20 + 16'(k), k == 18, 1'b0);
        idle(3);
        tests_run++;
        if (got_vec_q.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d strobes expected 3", got_vec_q.size());
        end
        for (int g = 0; g < 3 && g < got_vec_q.size(); g++) begin
            tests_run++;
            if (got_vec_q[g] !== build_vec(16'h20 + 16'(8 * g), exp_n[g])) begin
                tests_failed++;
                $display("FAIL b2b_vec%0d: got %0h expected %0h", g, got_vec_q[g],
                         build_vec(16'h20 + 16'(8 * g), exp_n[g]));
            end
            tests_run++;
            if (got_nv_q[g] !== NVW'(exp_n[g]) || got_last_q[g] !== exp_l[g]) begin
                tests_failed++;
                $display("FAIL b2b_tags%0d: got nv=%0d last=%b expected nv=%0d last=%b",
                         g, got_nv_q[g], got_last_q[g], exp_n[g], exp_l[g]);
            end
            tests_run++;
            if (got_cyc_q[g] - c0 + 1 != exp_cyc[g]) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d: got %0d expected %0d", g,
                         got_cyc_q[g] - c0 + 1, exp_cyc[g]);
            end
        end
    endtask

    task automatic test_flush_idle();
        int c0;
        clear_capture();
        c0 = cyc;
        for (int k = 0; k < 5; k++) drive(1'b1, 16'h40 + 16'(k), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        idle(3);
        tests_run++;
        if (got_vec_q.size() != 1) begin
            tests_failed++;
            $display("FAIL flush_count: got %0d strobes expected 1", got_vec_q.size());
        end
        if (got_vec_q.size() >= 1) begin
            tests_run++;
            if (got_vec_q[0] !== build_vec(16'h40, 5)) begin
                tests_failed++;
                $display("FAIL flush_vec: got %0h expected %0h", got_vec_q[0], build_vec(16'h40, 5));
            end
            tests_run++;
            if (got_nv_q[0] !== NVW'(5) || got_last_q[0] !== 1'b0 || got_cyc_q[0] - c0 + 1 != 7) begin
                tests_failed++;
                $display("FAIL flush_tags: got nv=%0d last=%b cycle=%0d expected nv=5 last=0 cycle=7",
                         got_nv_q[0], got_last_q[0], got_cyc_q[0] - c0 + 1);
            end
        end
    endtask

    task automatic test_flush_with_accept();
        int c0;
        clear_capture();
        c0 = cyc;
        for (int k = 0; k < 6; k++) drive(1'b1, 16'h60 + 16'(k), 1'b0, k == 5);
        drive(1'b1, 16'h70, 1'b0, 1'b0);
        drive(1'b1, 16'h71, 1'b1, 1'b1);
        idle(3);
        tests_run++;
        if (got_vec_q.size() != 2) begin
            tests_failed++;
            $display("FAIL flacc_count: got %0d strobes expected 2", got_vec_q.size());
        end
        if (got_vec_q.size() >= 2) begin
            tests_run++;
            if (got_vec_q[0] !== build_vec(16'h60, 6) || got_nv_q[0] !== NVW'(6) || got_last_q[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL flacc_first: got nv=%0d last=%b vec=%0h expected nv=6 last=0 vec=%0h",
                         got_nv_q[0], got_last_q[0], got_vec_q[0], build_vec(16'h60, 6));
            end
            tests_run++;
            if (got_vec_q[1] !== build_vec(16'h70, 2) || got_nv_q[1] !== NVW'(2) || got_last_q[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL flacc_second: got nv=%0d last=%b vec=%0h expected nv=2 last=1 vec=%0h",
                         got_nv_q[1], got_last_q[1], got_vec_q[1], build_vec(16'h70, 2));
            end
            tests_run++;
            if (got_cyc_q[0] - c0 + 1 != 7 || got_cyc_q[1] - c0 + 1 != 9) begin
                tests_failed++;
                $display("FAIL flacc_cycles: got %0d,%0d expected 7,9",
                         got_cyc_q[0] - c0 + 1, got_cyc_q[1] - c0 + 1);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        clear_capture();
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h80 + 16'(k), 1'b0, 1'b0);
        tests_run++;
        if (dbg_state !== ST_FILL) begin
            tests_failed++;
            $display("FAIL midgrp_state: got %0d expected %0d", dbg_state, ST_FILL);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || num_valid !== '0 || gathered !== '0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got valid=%b last=%b nv=%0d ready=%b vec=%0h expected all zero",
                     valid_o, last_o, num_valid, in_ready, gathered);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        tests_run++;
        if (in_ready !== 1'b1 || dbg_state !== ST_EMPTY) begin
            tests_failed++;
            $display("FAIL midrst_release: got ready=%b state=%0d expected ready=1 state=0",
                     in_ready, dbg_state);
        end
        for (int k = 0; k < 8; k++) drive(1'b1, 16'h90 + 16'(k), k == 7, 1'b0);
        idle(3);
        tests_run++;
        if (got_vec_q.size() != 1) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d strobes expected 1", got_vec_q.size());
        end
        if (got_vec_q.size() >= 1) begin
            tests_run++;
            if (got_vec_q[0] !== build_vec(16'h90, 8) || got_nv_q[0] !== NVW'(8) || got_last_q[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midrst_vec: got nv=%0d last=%b vec=%0h expected nv=8 last=1 vec=%0h",
                         got_nv_q[0], got_last_q[0], got_vec_q[0], build_vec(16'h90, 8));
            end
        end
    endtask

    task automatic test_random_gaps();
        pair cur [$];
        int sent;
        logic [15:0] k;
        logic l, f;
        logic [VW-1:0] v;
        clear_capture();
        exp_q.delete();
        exp_nv_q.delete();
        exp_last_q.delete();
        sent = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                f = ($urandom_range(0, 3) == 0);
                drive(1'b0, 16'h0, 1'b0, f);
                l = 1'b0;
            end else begin
                k = 16'($urandom_range(0, 65534));
                l = ($urandom_range(0, 15) == 0);
                f = ($urandom_range(0, 19) == 0);
                drive(1'b1, k, l, f);
                cur.push_back(mk_pair(k));
                sent++;
            end
            if (cur.size() > 0 && (cur.size() == N || l || f)) begin
                for (int i = 0; i < N; i++) v[i*PW +: PW] = (i < cur.size()) ? cur[i] : PAIR_PAD;
                exp_q.push_back(v);
                exp_nv_q.push_back(NVW'(cur.size()));
                exp_last_q.push_back(l);
                cur.delete();
            end
        end
        if (cur.size() > 0) begin
            drive(1'b0, 16'h0, 1'b0, 1'b1);
            for (int i = 0; i < N; i++) v[i*PW +: PW] = (i < cur.size()) ? cur[i] : PAIR_PAD;
            exp_q.push_back(v);
            exp_nv_q.push_back(NVW'(cur.size()));
            exp_last_q.push_back(1'b0);
            cur.delete();
        end
        idle(3);
        tests_run++;
        if (got_vec_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d strobes expected %0d", got_vec_q.size(), exp_q.size());
        end
        for (int g = 0; g < exp_q.size() && g < got_vec_q.size(); g++) begin
            tests_run++;
            if (got_vec_q[g] !== exp_q[g] || got_nv_q[g] !== exp_nv_q[g] || got_last_q[g] !== exp_last_q[g]) begin
                tests_failed++;
                $display("FAIL rand_vec%0d: got nv=%0d last=%b vec=%0h expected nv=%0d last=%b vec=%0h",
                         g, got_nv_q[g], got_last_q[g], got_vec_q[g],
                         exp_nv_q[g], exp_last_q[g], exp_q[g]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_full_group();
        test_back_to_back();
        test_flush_idle();
        test_flush_with_accept();
        test_reset_mid_group();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
